// File: rtl/lag_chan_rx_buffer.sv
// Receive-side flit buffer at the far end of a pipelined LAG channel.
// It is a circular FIFO that returns one registered credit for each flit the router consumes.
module lag_chan_rx_buffer #(
  parameter int  DEPTH  = 4,
  parameter int  CNT_W  = 3,
  parameter type flit_t = logic [15:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  flit_t            flit_in,
  input  logic             flit_valid_in,
  output logic             credit_out,
  output flit_t            flit_out,
  output logic             flit_valid_out,
  input  logic             flit_ready_in,
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow_err
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  flit_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  // A pop frees the head entry in the same cycle, so a full buffer can still accept a flit.
  always_comb begin
    full           = (occupancy == FULL);
    flit_valid_out = (occupancy != '0);
    pop            = flit_valid_out & flit_ready_in;
    push           = flit_valid_in & (~full | pop);
    flit_out       = flit_valid_out ? mem[rd_ptr] : '0;
  end

  // rst_n is active high in this block: 1 holds the buffer in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      occupancy <= occupancy + CNT_W'(1);
      else if (pop & ~push) occupancy <= occupancy - CNT_W'(1);
      credit_out <= pop;
      if (flit_valid_in & ~push) overflow_err <= 1'b1;
    end
  end

  // Storage has no reset; the output mux hides any stale entry while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push & ~rst_n) mem[wr_ptr] <= flit_in;
  end

endmodule

// File: doc/lag_chan_rx_buffer.md
LAG_CHAN_RX_BUFFER -- requirements
Module: LAG_chan_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the flit buffer entry count (power of 2, >=2).
REQ-002 Parameter CNT_W, default 3, SHALL set the occupancy width (= log2(DEPTH)+1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-high (1 = reset asserted).
REQ-005 flit_in  input  flit_t  SHALL carry the flit arriving from the far end of the pipelined channel.
REQ-006 flit_valid_in  input  1  SHALL qualify flit_in; one flit per cycle when high.
REQ-007 credit_out  output  1  SHALL be the credit returned upstream; one-cycle pulse per freed entry.
REQ-008 flit_out  output  flit_t  SHALL present the head-of-buffer flit to the router input stage.
REQ-009 flit_valid_out  output  1  SHALL be high when flit_out holds a valid flit.
REQ-010 flit_ready_in  input  1  SHALL indicate that the downstream stage consumes flit_out this cycle.
REQ-011 occupancy  output  CNT_W  SHALL give the number of buffered flits (0..DEPTH).
REQ-012 overflow_err  output  1  SHALL be a sticky flag for a flit arriving with no free entry.

Function
REQ-013 Push SHALL occur on any cycle with flit_valid_in=1 and (occupancy<DEPTH or pop=1).
REQ-014 Pop SHALL be defined as flit_valid_out & flit_ready_in; flit_ready_in is ignored when empty.
REQ-015 Storage SHALL be a circular buffer: write and read pointers, log2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-016 occupancy SHALL update as +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-017 flit_valid_out SHALL equal (occupancy!=0); flit_out SHALL equal the entry at the read pointer when valid, else '0.
REQ-018 Latency SHALL be one cycle: a flit pushed at edge N is visible on flit_out after edge N; no combinational bypass from flit_in to flit_out.
REQ-019 Order SHALL be strict FIFO; no flit reordered, duplicated or lost unless REQ-021 applies.
REQ-020 When full, simultaneous push and pop SHALL both succeed; occupancy stays DEPTH.
REQ-021 When full with flit_valid_in=1 and no pop, the flit SHALL be dropped, pointers and occupancy unchanged, and overflow_err set to 1 at the next edge.
REQ-022 overflow_err SHALL stay 1 until reset.
REQ-023 credit_out SHALL be registered: high for exactly the cycle after each pop, low otherwise; back-to-back pops give back-to-back credit pulses.
REQ-024 Credits returned SHALL equal pops exactly; an upstream sender initialised with DEPTH credits never overflows the buffer.
REQ-025 Pop on an empty buffer SHALL be impossible (REQ-014); no credit is issued.

Reset
REQ-026 While rst_n=1 at an edge: pointers=0, occupancy=0, flit_valid_out=0, flit_out='0, credit_out=0, overflow_err=0.
REQ-027 Reset mid-operation SHALL discard all buffered flits and any pending credit pulse; no credit issued for discarded flits.
REQ-028 Flits presented during reset SHALL be ignored; normal operation starts the first edge with rst_n=0.
REQ-029 Buffer storage SHALL NOT need reset; output masking per REQ-017 covers it.

Verification (DEPTH=4)
REQ-030 Reset, then push A,B,C on 3 consecutive cycles with flit_ready_in=0 -> occupancy 1,2,3; flit_out=A throughout; credit_out=0.
REQ-031 From REQ-030 state, flit_ready_in=1 for 3 cycles, no pushes -> flit_out A,B,C in order; credit_out high 3 consecutive cycles, each one cycle after its pop; occupancy ends 0; flit_valid_out=0.
REQ-032 Fill 4 flits, then push E with flit_ready_in=1 same cycle -> E accepted, occupancy stays 4, one credit pulse next cycle, overflow_err=0.
REQ-033 Fill 4 flits, push F with flit_ready_in=0 -> F dropped, overflow_err=1 from next cycle and held; subsequent pops output only the original 4 flits.
REQ-034 Push/pop streaming of 10 flits with continuous flit_ready_in=1 -> pointers wrap twice, output order matches input, 10 credit pulses total, occupancy never above 1.
REQ-035 With 3 flits buffered and a pop in progress, assert rst_n=1 for one cycle -> occupancy 0, flit_valid_out=0, credit_out=0 the next cycle and no later credit.
